i2c_cmd_seq: RTL and testbench

Register-transaction sequencer sitting directly upstream of the I2C master FSM. Accepts one register write or read request (7-bit device address, 8-bit register address, 8-bit data) via valid/ready handshake. Expands it into the master's command stream (START, WR, RESTART, RD, STOP), driving cmd/din/wr_i2c and consuming ready/done_tick/ack/dout. Returns read data plus a NACK/timeout status as a single-cycle response.

---
 rtl/i2c_pkg.sv | 72 +++++++
 rtl/i2c_cmd_seq.sv | 187 ++++++++++++++++++
 tb/tb_i2c_cmd_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master command codes plus the sequencer's step/state
// encodings and the step-to-command decode used to drive the master.
package i2c_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_START   = 3'd0,
    CMD_RESTART = 3'd1,
    CMD_STOP    = 3'd2,
    CMD_RD      = 3'd3,
    CMD_WR      = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    STEP_START,
    STEP_DEV_W,
    STEP_REG,
    STEP_DATA,
    STEP_RESTART,
    STEP_DEV_R,
    STEP_RD,
    STEP_STOP
  } step_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_WAIT_GAP,
    ST_RESP
  } state_e;

  typedef struct packed {
    cmd_e       cmd;
    logic [7:0] din;
  } mcmd_t;

  function automatic mcmd_t step_decode(input step_e step, input logic [6:0] dev,
                                        input logic [7:0] reg_addr, input logic [7:0] wdata);
    mcmd_t c;
    c.cmd = CMD_STOP;
    c.din = 8'h00;
    case (step)
      STEP_START:   c.cmd = CMD_START;
      STEP_DEV_W:   begin c.cmd = CMD_WR; c.din = {dev, 1'b0}; end
      STEP_REG:     begin c.cmd = CMD_WR; c.din = reg_addr; end
      STEP_DATA:    begin c.cmd = CMD_WR; c.din = wdata; end
      STEP_RESTART: c.cmd = CMD_RESTART;
      STEP_DEV_R:   begin c.cmd = CMD_WR; c.din = {dev, 1'b1}; end
      // Single-byte read: NACK the byte so the slave releases SDA before STOP
      STEP_RD:      begin c.cmd = CMD_RD; c.din = 8'h01; end
      default:      c.cmd = CMD_STOP;
    endcase
    return c;
  endfunction

  function automatic step_e step_next(input step_e step, input logic rw);
    step_e n;
    n = STEP_STOP;
    case (step)
      STEP_START:   n = STEP_DEV_W;
      STEP_DEV_W:   n = STEP_REG;
      STEP_REG:     n = rw ? STEP_RESTART : STEP_DATA;
      STEP_RESTART: n = STEP_DEV_R;
      STEP_DEV_R:   n = STEP_RD;
      default:      n = STEP_STOP;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/i2c_cmd_seq.sv
// Register-transaction sequencer: expands one register read/write request into
// the I2C master command stream and reports read data plus NACK/timeout status.
module i2c_cmd_seq
  import i2c_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [6:0]       req_dev,
  input  logic [7:0]       req_reg,
  input  logic [7:0]       req_wdata,
  output logic             resp_valid,
  output logic [7:0]       resp_rdata,
  output logic             resp_nack,
  output logic             resp_tmo,
  output logic [CMD_W-1:0] m_cmd,
  output logic [7:0]       m_din,
  output logic             m_wr,
  input  logic             m_ready,
  input  logic             m_done,
  input  logic             m_ack,
  input  logic [7:0]       m_dout
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  step_e            step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             nack_q, nack_d;
  logic             tmo_q, tmo_d;
  cmd_e             cmd_q, cmd_d;
  logic [7:0]       din_q, din_d;

  mcmd_t cur;
  logic  expired;

  assign cur     = step_decode(step_q, dev_q, reg_q, wdata_q);
  assign expired = (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_START;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cmd_q   <= CMD_STOP;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
      tmo_q   <= tmo_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    tmo_d   = tmo_q;
    cmd_d   = cmd_q;
    din_d   = din_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_ISSUE;
          step_d  = STEP_START;
          rw_d    = req_rw;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          rdata_d = 8'h00;
          nack_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (m_ready) begin
          cmd_d   = cur.cmd;
          din_d   = cur.din;
          state_d = (cur.cmd == CMD_WR || cur.cmd == CMD_RD) ? ST_WAIT_DONE : ST_WAIT_GAP;
        end else if (expired) begin
          tmo_d = 1'b1;
          if (step_q == STEP_STOP) state_d = ST_RESP;
          else                     step_d  = STEP_STOP;
        end
      end
      ST_WAIT_DONE: begin
        // A done tick in the expiry cycle still completes the byte normally
        if (m_done) begin
          state_d = ST_ISSUE;
          if (step_q == STEP_RD) begin
            rdata_d = m_dout;
            step_d  = step_next(step_q, rw_q);
          end else if (m_ack) begin
            nack_d = 1'b1;
            step_d = STEP_STOP;
          end else begin
            step_d = step_next(step_q, rw_q);
          end
        end else if (expired) begin
          tmo_d   = 1'b1;
          step_d  = STEP_STOP;
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_GAP: begin
        if (step_q == STEP_STOP) state_d = ST_RESP;
        else begin
          step_d  = step_next(step_q, rw_q);
          state_d = ST_ISSUE;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Fresh budget whenever the state or step changes; saturate otherwise
    if (state_d != state_q || step_d != step_q)
      cnt_d = '0;
    else if ((state_q == ST_ISSUE || state_q == ST_WAIT_DONE) && !expired)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  always_comb begin
    req_ready  = 1'b0;
    m_wr       = 1'b0;
    m_cmd      = cmd_q;
    m_din      = din_q;
    resp_valid = 1'b0;
    resp_rdata = 8'h00;
    resp_nack  = 1'b0;
    resp_tmo   = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE:  req_ready = 1'b1;
        ST_ISSUE: begin
          if (m_ready) begin
            m_wr  = 1'b1;
            m_cmd = cur.cmd;
            m_din = cur.din;
          end
        end
        ST_RESP: begin
          resp_valid = 1'b1;
          resp_nack  = nack_q;
          resp_tmo   = tmo_q;
          if (rw_q && !nack_q && !tmo_q) resp_rdata = rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Directed bench for i2c_cmd_seq with a behavioural master/slave responder
// and a strobe log compared against hand-written command sequences.
module tb_i2c_cmd_seq;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       resp_valid, resp_nack, resp_tmo;
  logic [7:0] resp_rdata;
  logic [2:0] m_cmd;
  logic [7:0] m_din;
  logic       m_wr, m_ready, m_done, m_ack;
  logic [7:0] m_dout;

  i2c_cmd_seq #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_nack(resp_nack), .resp_tmo(resp_tmo),
    .m_cmd(m_cmd), .m_din(m_din), .m_wr(m_wr), .m_ready(m_ready),
    .m_done(m_done), .m_ack(m_ack), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int proto_err = 0;

  // Responder controls
  logic       ready_en = 1'b1;
  logic       hang_mode = 1'b0;
  logic       nack_mode = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  logic       strobe_seen = 1'b0;
  logic [2:0] strobe_cmd = 3'd0;
  logic       prev_wr = 1'b0;
  int         done_wait = 0;
  int         gap_wait = 0;

  logic [10:0] log_q[$];
  int          log_cyc[$];
  logic [10:0] exp_q[$];

  logic [7:0] r_rdata;
  logic       r_nack, r_tmo;
  int         acc_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every strobe and police the strobe protocol
  always @(negedge clk) begin
    strobe_seen = m_wr;
    strobe_cmd  = m_cmd;
    if (m_wr) begin
      log_q.push_back({m_cmd, m_din});
      log_cyc.push_back(cyc);
      if (!m_ready) proto_err++;
      if (prev_wr)  proto_err++;
    end
    prev_wr = m_wr;
  end

  // Behavioural master: byte commands finish after a few cycles, bus
  // conditions drop ready for exactly one cycle
  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    if (reset) begin
      done_wait = 0;
      gap_wait  = 0;
      m_ready   = ready_en;
    end else if (strobe_seen) begin
      if (strobe_cmd == CMD_WR || strobe_cmd == CMD_RD) begin
        m_ready   = hang_mode ? ready_en : 1'b0;
        done_wait = hang_mode ? 0 : 2;
      end else begin
        m_ready  = 1'b0;
        gap_wait = 1;
      end
    end else if (done_wait > 0) begin
      done_wait--;
      if (done_wait == 0) begin
        m_done  = 1'b1;
        m_ack   = nack_mode;
        m_dout  = rd_byte;
        m_ready = ready_en;
      end
    end else if (gap_wait > 0) begin
      gap_wait = 0;
      m_ready  = ready_en;
    end else begin
      m_ready = ready_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag);
    check({tag, " len"}, log_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < log_q.size()) check($sformatf("%s step%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req accepted", req_ready, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (resp_valid) break;
      n++;
    end
    check({tag, " resp seen"}, resp_valid, 1'b1);
    check({tag, " ready low in resp"}, req_ready, 1'b0);
    r_rdata = resp_rdata;
    r_nack  = resp_nack;
    r_tmo   = resp_tmo;
    @(negedge clk);
    check({tag, " resp one cycle"}, resp_valid, 1'b0);
    check({tag, " ready after resp"}, req_ready, 1'b1);
    $display("txn %s: rdata=%02h nack=%0d tmo=%0d strobes=%0d", tag, r_rdata, r_nack, r_tmo,
             log_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_dev = '0; req_reg = '0; req_wdata = '0;
    m_ready = 1'b1; m_done = 1'b0; m_ack = 1'b0; m_dout = '0;
    repeat (3) @(negedge clk);
    check("rst req_ready", req_ready, 1'b0);
    check("rst resp_valid", resp_valid, 1'b0);
    check("rst resp_rdata", resp_rdata, 8'h00);
    check("rst resp_nack", resp_nack, 1'b0);
    check("rst resp_tmo", resp_tmo, 1'b0);
    check("rst m_cmd", m_cmd, 3'd2);
    check("rst m_din", m_din, 8'h00);
    check("rst m_wr", m_wr, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("post rst req_ready", req_ready, 1'b1);

    // Plain register write
    log_q.delete(); log_cyc.delete();
    send_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_resp("write");
    exp_q = '{11'h000, 11'h4A0, 11'h410, 11'h4A5, 11'h200};
    check_seq("write seq");
    check("write first strobe latency", log_cyc[0] - acc_cyc, 0);
    check("write nack", r_nack, 1'b0);
    check("write tmo", r_tmo, 1'b0);
    check("write rdata", r_rdata, 8'h00);
    check("held m_cmd", m_cmd, 3'd2);

    // Register read
    log_q.delete(); log_cyc.delete();
    rd_byte = 8'h3C;
    send_req(1'b1, 7'h50, 8'h22, 8'hFF);
    wait_resp("read");
    exp_q = '{11'h000, 11'h4A0, 11'h422, 11'h100, 11'h4A1, 11'h301, 11'h200};
    check_seq("read seq");
    check("read rdata", r_rdata, 8'h3C);
    check("read nack", r_nack, 1'b0);
    check("read tmo", r_tmo, 1'b0);

    // Address NACK on a read: abort straight to STOP, no data returned
    log_q.delete(); log_cyc.delete();
    nack_mode = 1'b1; rd_byte = 8'h77;
    send_req(1'b1, 7'h50, 8'h22, 8'h00);
    wait_resp("nack");
    nack_mode = 1'b0;
    exp_q = '{11'h000, 11'h4A0, 11'h200};
    check_seq("nack seq");
    check("nack flag", r_nack, 1'b1);
    check("nack tmo", r_tmo, 1'b0);
    check("nack rdata", r_rdata, 8'h00);

    // Master never finishes the byte: 16 cycles in WAIT_DONE then STOP
    log_q.delete(); log_cyc.delete();
    hang_mode = 1'b1;
    send_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_resp("timeout");
    hang_mode = 1'b0;
    exp_q = '{11'h000, 11'h4A0, 11'h200};
    check_seq("timeout seq");
    if (log_cyc.size() == 3) check("timeout stop delay", log_cyc[2] - log_cyc[1], 17);
    else check("timeout strobe count", log_cyc.size(), 3);
    check("timeout tmo", r_tmo, 1'b1);
    check("timeout nack", r_nack, 1'b0);
    check("timeout rdata", r_rdata, 8'h00);

    // Reset while waiting for the device-address byte of a read
    log_q.delete(); log_cyc.delete();
    rd_byte = 8'h5A;
    send_req(1'b1, 7'h50, 8'h22, 8'h00);
    for (int n = 0; n < 50 && log_q.size() < 2; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst m_wr", m_wr, 1'b0);
    check("midrst m_cmd", m_cmd, 3'd2);
    check("midrst m_din", m_din, 8'h00);
    check("midrst resp_valid", resp_valid, 1'b0);
    check("midrst req_ready", req_ready, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst no stop", log_q.size(), 2);
    check("midrst idle", req_ready, 1'b1);
    log_q.delete(); log_cyc.delete();
    send_req(1'b0, 7'h21, 8'h04, 8'h9E);
    wait_resp("after rst");
    exp_q = '{11'h000, 11'h442, 11'h404, 11'h49E, 11'h200};
    check_seq("after rst seq");
    check("after rst nack", r_nack, 1'b0);

    // m_ready held low before START while a second request waits
    log_q.delete(); log_cyc.delete();
    ready_en = 1'b0;
    send_req(1'b0, 7'h50, 8'h10, 8'hA5);
    req_valid = 1'b1; req_rw = 1'b1; req_dev = 7'h11; req_reg = 8'h33; rd_byte = 8'hC3;
    repeat (10) @(negedge clk);
    check("hold no strobe", log_q.size(), 0);
    check("hold busy", req_ready, 1'b0);
    ready_en = 1'b1;
    wait_resp("held");
    exp_q = '{11'h000, 11'h4A0, 11'h410, 11'h4A5, 11'h200};
    check_seq("held seq");
    log_q.delete(); log_cyc.delete();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_resp("second");
    exp_q = '{11'h000, 11'h422, 11'h433, 11'h100, 11'h423, 11'h301, 11'h200};
    check_seq("second seq");
    check("second rdata", r_rdata, 8'hC3);

    check("strobe protocol", proto_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
